alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the 16-bit ALU interface. Accepts one instruction at a time over a
//  valid/ready handshake and reads operands from an internal register file. Drives the
//  ALU's A/B/F/Cin inputs from registers, captures Result/Status, and writes the result
//  back to the register file and the status to a flags register. Feeds the ALU's
//  combinational datapath; the ALU itself sits outside this block.
// PARAMETERS
//  NREG    8   number of 16-bit registers in the register file (power of 2, >= 2)
//  ADDR_W  3   register address width, must equal log2(NREG)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  instr_valid  in   1       instruction present
//  instr_ready  out  1       block can accept; high only in IDLE
//  instr_op     in   5       ALU function code; 5'b00000 = LDI (load immediate)
//  instr_rd     in   ADDR_W  destination register
//  instr_rs1    in   ADDR_W  source register driven on alu_a
//  instr_rs2    in   ADDR_W  source register driven on alu_b
//  instr_imm    in   16      immediate value, used by LDI only
//  alu_a        out  16      ALU operand A (registered)
//  alu_b        out  16      ALU operand B (registered)
//  alu_f        out  5       ALU function (registered)
//  alu_cin      out  1       ALU carry-in = flags[5] sampled at accept (registered)
//  alu_result   in   16      ALU Result
//  alu_status   in   6       ALU Status {C,Z,N,V,P,AC}, bit 5 = C ... bit 0 = AC
//  flags        out  6       architectural flags register
//  done         out  1       one-cycle pulse: instruction retired
//  err          out  1       one-cycle pulse, concurrent with done: illegal opcode
//  dbg_addr     in   ADDR_W  debug read address
//  dbg_data     out  16      rf[dbg_addr], combinational read
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all rf entries, flags, alu_a/alu_b/alu_f/alu_cin,
//    done, and err = 0. An in-flight instruction is dropped with no writeback.
//    instr_ready=1 from the first cycle after release.
//  - Legal ALU opcodes: 00001,00011,00100-00111,01000-01011,10000-10111.
//    LDI=00000. Every other code is illegal.
//  - FSM: IDLE -> EXEC -> DONE -> IDLE. Throughput: one instruction per 3 cycles.
//  - IDLE: instr_ready=1. Accept on the edge where instr_valid&&instr_ready. At that edge:
//    alu_a<=rf[rs1], alu_b<=rf[rs2], alu_f<=instr_op, alu_cin<=flags[5]. Latch rd, op, and
//    imm. Go to EXEC. instr_* is ignored while not in IDLE.
//  - EXEC: ALU settles combinationally; alu_* stay stable. On the next edge:
//    - legal ALU op: rf[rd]<=alu_result, flags<=alu_status.
//    - LDI: rf[rd]<=imm, flags unchanged.
//    - illegal: no rf or flags write; err<=1.
//    In all cases done<=1, go to DONE.
//  - DONE: done=1 (and err if set) for exactly this cycle. instr_ready=0.
//    Next edge: done<=0, err<=0, go to IDLE.
//  - Latency: done is high in the 2nd cycle after the accept edge.
//    dbg_data reflects the writeback in that same cycle.
//  - rd may equal rs1/rs2. Operands are read at accept, so old values are used.
//    Back-to-back dependency is safe because issue is serialized.
//  - alu_* hold their last values in IDLE/DONE; no glitching between instructions.
//  - No register is hard-wired to zero. Widths are exact 16-bit.
//  - Carry semantics belong to the ALU; this block only routes flags[5] to alu_cin.
// TESTING
//  1 Reset with instr_valid=1 held -> flags=0, dbg_data=0 for all addrs, done=0;
//    first accept occurs on the first edge after rst_n rises.
//  2 LDI r1=7FFF, LDI r2=0001, ADD(00100) r3=r1,r2 -> r3=8000, flags=6'b001101, err=0.
//  3 LDI r4=FFFF; ADD r5=r4,r2 -> r5=0000, flags C=1,Z=1; then ADDC(00101) r6=r2,r2 with
//    alu_cin=1 -> r6=0003.
//  4 Illegal op 01100 after test 3 -> done=1 with err=1; rd unchanged; flags unchanged.
//  5 instr_valid held high for 10 cycles with ready toggling -> accepted every 3rd cycle;
//    instr_ready low in EXEC/DONE; no duplicate or missed accepts.
//  6 rst_n pulsed low during EXEC of ADD r7 -> r7 stays 0, no done pulse;
//    IDLE with instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issues one instruction at a time to an external 16-bit combinational ALU.
// Operands come from an internal register file. The ALU result is written
// back to the register file and the ALU status to the flags register.
//
// Sequence: IDLE (accept) -> EXEC (ALU settles) -> DONE (done pulse) -> IDLE.
// Throughput is one instruction every 3 cycles.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instr_valid/ready   instruction handshake; ready is high only in IDLE
//   instr_op            5-bit function code, 5'b00000 = LDI
//   instr_rd/rs1/rs2    destination and source register addresses
//   instr_imm           immediate value, used by LDI only
//   alu_a/b/f/cin       registered ALU inputs, held between instructions
//   alu_result/status   ALU outputs, status = {C,Z,N,V,P,AC}
//   flags               architectural flags register
//   done, err           one-cycle retire pulse; err marks an illegal opcode
//   dbg_addr/dbg_data   combinational register-file read port
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [15:0]       instr_imm,

    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [4:0]        alu_f,
    output logic              alu_cin,
    input  logic [15:0]       alu_result,
    input  logic [5:0]        alu_status,

    output logic [5:0]        flags,
    output logic              done,
    output logic              err,

    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [15:0]       dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_LDI = 5'b00000;

    state_t              r_state;
    logic [15:0]         r_rf [NREG];
    logic [5:0]          r_flags;
    logic [15:0]         r_alu_a;
    logic [15:0]         r_alu_b;
    logic [4:0]          r_alu_f;
    logic                r_alu_cin;
    logic                r_done;
    logic                r_err;

    // Instruction fields latched at accept; instr_* is ignored afterwards.
    logic [ADDR_W-1:0]   r_rd;
    logic [4:0]          r_op;
    logic [15:0]         r_imm;

    logic                w_is_ldi;
    logic                w_is_legal;

    assign w_is_ldi = (r_op == OP_LDI);

    // Legal ALU codes: 00001, 00011, 00100-00111, 01000-01011, 10000-10111.
    always_comb begin
        w_is_legal = 1'b0;
        if (r_op == 5'b00001 || r_op == 5'b00011)
            w_is_legal = 1'b1;
        else if (r_op[4:2] == 3'b001 || r_op[4:2] == 3'b010)
            w_is_legal = 1'b1;
        else if (r_op[4:3] == 2'b10)
            w_is_legal = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            for (int unsigned i = 0; i < NREG; i++)
                r_rf[i] <= '0;
            r_flags   <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_f   <= '0;
            r_alu_cin <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd      <= '0;
            r_op      <= '0;
            r_imm     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        // Operands are read here, so rd==rs uses the old value.
                        r_alu_a   <= r_rf[instr_rs1];
                        r_alu_b   <= r_rf[instr_rs2];
                        r_alu_f   <= instr_op;
                        r_alu_cin <= r_flags[5];
                        r_rd      <= instr_rd;
                        r_op      <= instr_op;
                        r_imm     <= instr_imm;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_ldi) begin
                        r_rf[r_rd] <= r_imm;
                    end else if (w_is_legal) begin
                        r_rf[r_rd] <= alu_result;
                        r_flags    <= alu_status;
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_f       = r_alu_f;
    assign alu_cin     = r_alu_cin;
    assign flags       = r_flags;
    assign done        = r_done;
    assign err         = r_err;
    assign dbg_data    = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/100ps
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic [15:0] instr_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic [5:0]  alu_status;
    logic [5:0]  flags;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;

    alu_issue_ctrl #(.NREG(8), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_cin     (alu_cin),
        .alu_result  (alu_result),
        .alu_status  (alu_status),
        .flags       (flags),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {result, C, Z, N, V, P(even), AC}.
    // Undefined codes return a poison value so an illegal writeback shows up.
    function automatic logic [21:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [4:0] f, input logic cin);
        logic [16:0] s;
        logic [15:0] r;
        logic [15:0] bb;
        logic        ci, arith, c, v, ac;
        arith = 1'b0; bb = b; ci = 1'b0; r = '0;
        case (f) inside
            5'd1:        begin arith = 1'b1; bb = 16'h0; ci = 1'b1; end
            5'd3:        r = ~a;
            5'd4:        arith = 1'b1;
            5'd5:        begin arith = 1'b1; ci = cin; end
            5'd6:        begin arith = 1'b1; bb = ~b; ci = 1'b1; end
            5'd7:        begin arith = 1'b1; bb = ~b; ci = cin; end
            5'd8:        r = a & b;
            5'd9:        r = a | b;
            5'd10:       r = a ^ b;
            5'd11:       r = ~(a & b);
            [5'd16:5'd23]: r = (a << f[2:0]) ^ b;
            default:     return {16'hDEAD, 6'h3F};
        endcase
        c = 1'b0; v = 1'b0; ac = 1'b0;
        if (arith) begin
            s  = {1'b0, a} + {1'b0, bb} + 17'(ci);
            r  = s[15:0];
            c  = s[16];
            v  = (a[15] == bb[15]) && (r[15] != a[15]);
            ac = ({1'b0, a[3:0]} + {1'b0, bb[3:0]} + 5'(ci)) > 5'd15;
        end
        return {r, c, (r == 16'h0), r[15], v, ~^r, ac};
    endfunction

    always_comb {alu_result, alu_status} = alu_fn(alu_a, alu_b, alu_f, alu_cin);

    // Architectural reference state.
    logic [15:0] ref_rf [8];
    logic [5:0]  ref_flags;

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        ref_flags = '0;
    endtask

    task automatic ref_step(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic [15:0] imm, output logic e_err);
        logic [21:0] o;
        e_err = 1'b0;
        if (op == 5'd0) begin
            ref_rf[rd] = imm;
        end else if (op inside {5'd1, 5'd3, [5'd4:5'd11], [5'd16:5'd23]}) begin
            o = alu_fn(ref_rf[rs1], ref_rf[rs2], op, ref_flags[5]);
            ref_rf[rd] = o[21:6];
            ref_flags  = o[5:0];
        end else begin
            e_err = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [15:0] obs_val;
    logic [5:0]  obs_flags;
    logic        obs_err;
    logic        obs_cin;

    // Called at a falling edge with the DUT in IDLE; returns at the falling
    // edge of the following IDLE cycle.
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm);
        logic [15:0] e_a, e_b;
        logic        e_cin, e_err;
        e_a   = ref_rf[rs1];
        e_b   = ref_rf[rs2];
        e_cin = ref_flags[5];
        ref_step(op, rd, rs1, rs2, imm, e_err);

        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        check("ready_idle", 32'(instr_ready), 32'd1);

        @(posedge clk); @(negedge clk);
        // Garbage with valid held high must be ignored outside IDLE.
        instr_op = 5'($urandom); instr_rd = 3'($urandom); instr_rs1 = 3'($urandom);
        instr_rs2 = 3'($urandom); instr_imm = 16'($urandom);
        check("exec_done",  32'(done),        32'd0);
        check("exec_ready", 32'(instr_ready), 32'd0);
        check("alu_a",      32'(alu_a),       32'(e_a));
        check("alu_b",      32'(alu_b),       32'(e_b));
        check("alu_f",      32'(alu_f),       32'(op));
        check("alu_cin",    32'(alu_cin),     32'(e_cin));
        obs_cin = alu_cin;

        @(posedge clk); @(negedge clk);
        dbg_addr = rd;
        #1;
        check("done_pulse", 32'(done),        32'd1);
        check("err",        32'(err),         32'(e_err));
        check("done_ready", 32'(instr_ready), 32'd0);
        check("flags",      32'(flags),       32'(ref_flags));
        check("rd_val",     32'(dbg_data),    32'(ref_rf[rd]));
        obs_val = dbg_data; obs_flags = flags; obs_err = err;

        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        check("idle_done",  32'(done),        32'd0);
        check("idle_err",   32'(err),         32'd0);
        check("idle_ready", 32'(instr_ready), 32'd1);
        check("alu_a_hold", 32'(alu_a),       32'(e_a));
        check("alu_f_hold", 32'(alu_f),       32'(op));
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic [15:0] exp_val;
        logic [5:0]  exp_flags;
        logic        exp_cin;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_cnt, done_cnt;
        logic [4:0] rop;

        vecs[0] = '{5'b00000, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 6'b000000, 1'b0, 1'b0};
        vecs[1] = '{5'b00000, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 6'b000000, 1'b0, 1'b0};
        vecs[2] = '{5'b00100, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h8000, 6'b001101, 1'b0, 1'b0};
        vecs[3] = '{5'b00000, 3'd4, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 6'b001101, 1'b0, 1'b0};
        vecs[4] = '{5'b00100, 3'd5, 3'd4, 3'd2, 16'h0000, 16'h0000, 6'b110011, 1'b0, 1'b0};
        vecs[5] = '{5'b00101, 3'd6, 3'd2, 3'd2, 16'h0000, 16'h0003, 6'b000010, 1'b1, 1'b0};
        vecs[6] = '{5'b01100, 3'd6, 3'd1, 3'd2, 16'h1111, 16'h0003, 6'b000010, 1'b0, 1'b1};

        // Reset with a valid LDI already presented.
        ref_reset();
        rst_n = 1'b0;
        instr_valid = 1'b1; instr_op = 5'd0; instr_rd = 3'd1;
        instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_imm = 16'h1234; dbg_addr = 3'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dbg_addr = 3'(i);
            #1;
            check("rst_dbg", 32'(dbg_data), 32'd0);
        end
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'd0, 3'd1, 3'd0, 3'd0, 16'h1234);

        // Directed vectors.
        foreach (vecs[k]) begin
            issue(vecs[k].op, vecs[k].rd, vecs[k].rs1, vecs[k].rs2, vecs[k].imm);
            check("vec_val",   32'(obs_val),   32'(vecs[k].exp_val));
            check("vec_flags", 32'(obs_flags), 32'(vecs[k].exp_flags));
            check("vec_err",   32'(obs_err),   32'(vecs[k].exp_err));
            check("vec_cin",   32'(obs_cin),   32'(vecs[k].exp_cin));
        end

        // instr_valid held high: one accept every third cycle.
        instr_op = 5'b00100; instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd2;
        instr_imm = 16'h0; instr_valid = 1'b1;
        acc_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (c != 0) @(negedge clk);
            check("stream_ready", 32'(instr_ready), 32'((c % 3) == 0));
            check("stream_done",  32'(done),        32'((c % 3) == 2));
            if (instr_ready) acc_cnt++;
            if (done) done_cnt++;
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic e;
            ref_step(5'b00100, 3'd0, 3'd0, 3'd2, 16'h0, e);
        end
        @(posedge clk); @(negedge clk);
        check("stream_accepts", 32'(acc_cnt),  32'd10);
        check("stream_dones",   32'(done_cnt), 32'd10);
        dbg_addr = 3'd0;
        #1;
        check("stream_r0",    32'(dbg_data), 32'(ref_rf[0]));
        check("stream_flags", 32'(flags),    32'(ref_flags));

        // Randomized instructions against the reference model.
        for (int n = 0; n < 60; n++) begin
            rop = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            issue(rop, 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
        end

        // Reset pulse during EXEC of ADD r7.
        instr_op = 5'b00100; instr_rd = 3'd7; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        check("abort_exec_ready", 32'(instr_ready), 32'd0);
        rst_n = 1'b0;
        ref_reset();
        #1;
        check("abort_rst_done", 32'(done), 32'd0);
        @(posedge clk); @(negedge clk);
        check("abort_rst_done2", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done),        32'd0);
            check("abort_ready",   32'(instr_ready), 32'd1);
        end
        dbg_addr = 3'd7;
        #1;
        check("abort_r7",    32'(dbg_data), 32'd0);
        check("abort_flags", 32'(flags),    32'd0);
        issue(5'd0, 3'd3, 3'd0, 3'd0, 16'hBEEF);
        issue(5'b00100, 3'd7, 3'd3, 3'd3, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
